// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: access-size encodings, arbiter
// states, wait-counter width and the alignment rule for data requests.
package mem_arbiter_pkg;

  localparam int WAIT_W = 8;

  localparam logic [2:0] MODE_WORD  = 3'd0;
  localparam logic [2:0] MODE_HALF  = 3'd1;
  localparam logic [2:0] MODE_HALFU = 3'd2;
  localparam logic [2:0] MODE_BYTE  = 3'd3;
  localparam logic [2:0] MODE_BYTEU = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_D  = 2'd1,
    BUSY_IF = 2'd2
  } arb_state_t;

  // Encodings 5-7 are handled as word accesses, so they need word alignment.
  function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] lo);
    logic mis;
    case (mode)
      MODE_HALF, MODE_HALFU: mis = lo[0];
      MODE_BYTE, MODE_BYTEU: mis = 1'b0;
      default:               mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// Byte-lane logic for one access: byte enables, store-data replication
// into every lane and sign/zero extension of the selected load lane.
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = 8'(rdata >> {addr_lo, 3'b000});
  assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (mode)
      MODE_HALF, MODE_HALFU: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = (mode == MODE_HALF) ? {{16{half_lane[15]}}, half_lane}
                                        : {16'h0000, half_lane};
      end
      MODE_BYTE, MODE_BYTEU: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = (mode == MODE_BYTE) ? {{24{byte_lane[7]}}, byte_lane}
                                        : {24'h000000, byte_lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data accesses take priority over
// instruction fetches, one outstanding access at a time, with a wait timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_memread,
  input  logic        d_memwrite,
  input  logic [2:0]  d_mode,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT - 1);

  arb_state_t        state, state_next;
  logic [31:0]       lat_addr, lat_wdata;
  logic [2:0]        lat_mode;
  logic              lat_we;
  logic [WAIT_W-1:0] wait_cnt;
  logic              if_ready_q, d_ready_q, d_err_q;
  logic [31:0]       if_rdata_q, d_rdata_q;
  logic              d_pending, f_pending, d_mis, busy, timed_out, finish;
  logic              grant_d, grant_if;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata, lane_rdata;

  // A requester still showing its ready pulse is holding a finished request.
  assign d_pending = (d_memread | d_memwrite) & ~d_ready_q;
  assign f_pending = if_req & ~if_ready_q;
  assign d_mis     = d_pending & is_misaligned(d_mode, d_addr[1:0]);
  assign busy      = (state != IDLE);
  assign timed_out = busy & ~mem_ack & (wait_cnt == TO_LAST);
  assign finish    = busy & (mem_ack | timed_out);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_if   = 1'b0;
    case (state)
      IDLE: begin
        if (d_pending && !d_mis) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (f_pending) begin
          grant_if   = 1'b1;
          state_next = BUSY_IF;
        end
      end
      BUSY_D, BUSY_IF: if (mem_ack || timed_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_mode  <= MODE_WORD;
      lat_we    <= 1'b0;
    end else if (grant_d) begin
      lat_addr  <= d_addr;
      lat_wdata <= d_wdata;
      lat_mode  <= d_mode;
      lat_we    <= d_memwrite;
    end else if (grant_if) begin
      lat_addr  <= if_addr;
      lat_wdata <= '0;
      lat_mode  <= MODE_WORD;
      lat_we    <= 1'b0;
    end
  end

  // Responses are single-cycle pulses; read data is zero outside them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt   <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      wait_cnt   <= (busy && !mem_ack) ? wait_cnt + 1'b1 : '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if (finish && state == BUSY_D) begin
        d_ready_q <= 1'b1;
        d_err_q   <= ~mem_ack;
        d_rdata_q <= mem_ack ? lane_rdata : '0;
      end
      if (finish && state == BUSY_IF) begin
        if_ready_q <= 1'b1;
        if_rdata_q <= mem_ack ? lane_rdata : '0;
      end
      if (state == IDLE && d_mis) begin
        d_ready_q <= 1'b1;
        d_err_q   <= 1'b1;
      end
    end
  end

  mem_lane_align u_align (
    .mode      (lat_mode),
    .addr_lo   (lat_addr[1:0]),
    .wdata     (lat_wdata),
    .rdata     (mem_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  assign mem_en    = busy;
  assign mem_we    = busy & lat_we;
  assign mem_be    = busy ? lane_be : 4'b0000;
  assign mem_addr  = {lat_addr[31:2], 2'b00};
  assign mem_wdata = lane_wdata;

  assign if_ready = if_ready_q;
  assign if_rdata = if_rdata_q;
  assign d_ready  = d_ready_q;
  assign d_rdata  = d_rdata_q;
  assign d_err    = d_err_q;
  assign stall    = (if_req & ~if_ready_q) | ((d_memread | d_memwrite) & ~d_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus directed sequences,
// with scoreboard queues for memory issues and ready responses.
module tb_mem_arbiter;

  logic        clk, reset;
  logic        if_req, if_ready;
  logic [31:0] if_addr, if_rdata;
  logic        d_memread, d_memwrite, d_ready, d_err, stall;
  logic [2:0]  d_mode;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic        ack_enable = 1'b1;
  logic        stray_ack  = 1'b0;
  logic        prev_en    = 1'b0;
  logic [31:0] mem_img [logic [31:0]];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } mem_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } d_exp_t;

  typedef struct {
    logic        fetch, rd, wr;
    logic [2:0]  mode;
    logic [31:0] addr, wdata, mem_word;
    logic        no_ack;
    int          exp_lat, exp_en;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwdata;
    logic        exp_we, chk_rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  mem_exp_t    mem_q[$];
  d_exp_t      d_q[$];
  logic [31:0] if_q[$];
  vec_t        vecs [16];

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_memread(d_memread), .d_memwrite(d_memwrite), .d_mode(d_mode),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportUnexpected(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got unexpected event expected none at %0t", name, $time);
  endtask

  // Memory model: checks the first cycle of each issue, then answers.
  always @(negedge clk) begin
    mem_exp_t e;
    if (mem_en && !prev_en) begin
      if (mem_q.size() == 0) reportUnexpected("mem_issue");
      else begin
        e = mem_q.pop_front();
        checkOutput("mem_addr", mem_addr, e.addr);
        checkOutput("mem_be", {28'h0, mem_be}, {28'h0, e.be});
        checkOutput("mem_we", {31'h0, mem_we}, {31'h0, e.we});
        if (e.we) checkOutput("mem_wdata", mem_wdata, e.wdata);
      end
    end
    prev_en   = mem_en;
    mem_ack   = (mem_en & ack_enable) | stray_ack;
    mem_rdata = (mem_en && mem_img.exists(mem_addr)) ? mem_img[mem_addr] : 32'h0BADF00D;
  end

  // Response scoreboard.
  always @(negedge clk) begin
    d_exp_t de;
    logic [31:0] fe;
    if (!reset) begin
      if (d_ready) begin
        if (d_q.size() == 0) reportUnexpected("d_ready");
        else begin
          de = d_q.pop_front();
          checkOutput("d_err", {31'h0, d_err}, {31'h0, de.err});
          if (de.chk) checkOutput("d_rdata", d_rdata, de.rdata);
        end
      end else begin
        checkOutput("d_rdata_idle", d_rdata, 32'h0);
        checkOutput("d_err_idle", {31'h0, d_err}, 32'h0);
      end
      if (if_ready) begin
        if (if_q.size() == 0) reportUnexpected("if_ready");
        else begin
          fe = if_q.pop_front();
          checkOutput("if_rdata", if_rdata, fe);
        end
      end else begin
        checkOutput("if_rdata_idle", if_rdata, 32'h0);
      end
    end
  end

  task automatic applyStimulus(input vec_t v, input int idx);
    int  en_cycles = 0;
    int  lat = -1;
    logic rdy;
    string tag;
    tag = $sformatf("vec%0d", idx);
    mem_img[{v.addr[31:2], 2'b00}] = v.mem_word;
    if (v.exp_en > 0) mem_q.push_back('{v.exp_maddr, v.exp_be, v.exp_mwdata, v.exp_we});
    if (v.fetch) if_q.push_back(v.exp_rdata);
    else d_q.push_back('{v.exp_rdata, v.exp_err, v.chk_rdata});
    @(posedge clk); #1;
    ack_enable = ~v.no_ack;
    if (v.fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      d_memread = v.rd; d_memwrite = v.wr; d_mode = v.mode;
      d_addr = v.addr; d_wdata = v.wdata;
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      rdy = v.fetch ? if_ready : d_ready;
      checkOutput({tag, "_stall"}, {31'h0, stall}, {31'h0, (n < v.exp_lat)});
      if (mem_en) en_cycles++;
      if (rdy) begin
        lat = n;
        break;
      end
    end
    checkOutput({tag, "_latency"}, lat, v.exp_lat);
    checkOutput({tag, "_en_cycles"}, en_cycles, v.exp_en);
    @(posedge clk); #1;
    if_req = 1'b0; d_memread = 1'b0; d_memwrite = 1'b0;
    ack_enable = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d_n, f_n;
    logic d_done, f_done;

    //            f rd wr mode addr          wdata         mem_word      na lat en maddr         be       mwdata        we chk rdata         err
    vecs[0]  = '{1,0,0,3'd0,32'h0000_0040,32'h0,        32'h1234_5678,0, 2, 1, 32'h0000_0040,4'b1111,32'h0,        0, 1, 32'h1234_5678,0};
    vecs[1]  = '{0,1,0,3'd3,32'h0000_0103,32'h0,        32'h80FF_0000,0, 2, 1, 32'h0000_0100,4'b1000,32'h0,        0, 1, 32'hFFFF_FF80,0};
    vecs[2]  = '{0,1,0,3'd4,32'h0000_0103,32'h0,        32'h80FF_0000,0, 2, 1, 32'h0000_0100,4'b1000,32'h0,        0, 1, 32'h0000_0080,0};
    vecs[3]  = '{0,1,0,3'd1,32'h0000_0102,32'h0,        32'h80FF_0000,0, 2, 1, 32'h0000_0100,4'b1100,32'h0,        0, 1, 32'hFFFF_80FF,0};
    vecs[4]  = '{0,1,0,3'd2,32'h0000_0102,32'h0,        32'h80FF_0000,0, 2, 1, 32'h0000_0100,4'b1100,32'h0,        0, 1, 32'h0000_80FF,0};
    vecs[5]  = '{0,1,0,3'd0,32'h0000_0100,32'h0,        32'h80FF_0000,0, 2, 1, 32'h0000_0100,4'b1111,32'h0,        0, 1, 32'h80FF_0000,0};
    vecs[6]  = '{0,1,0,3'd3,32'h0000_0101,32'h0,        32'h1234_7F56,0, 2, 1, 32'h0000_0100,4'b0010,32'h0,        0, 1, 32'h0000_007F,0};
    vecs[7]  = '{0,1,0,3'd1,32'h0000_0100,32'h0,        32'h0000_F00D,0, 2, 1, 32'h0000_0100,4'b0011,32'h0,        0, 1, 32'hFFFF_F00D,0};
    vecs[8]  = '{0,1,0,3'd5,32'h0000_010C,32'h0,        32'hCAFE_F00D,0, 2, 1, 32'h0000_010C,4'b1111,32'h0,        0, 1, 32'hCAFE_F00D,0};
    vecs[9]  = '{0,0,1,3'd3,32'h0000_0201,32'h1234_56AB,32'h0,        0, 2, 1, 32'h0000_0200,4'b0010,32'hABAB_ABAB,1, 0, 32'h0,        0};
    vecs[10] = '{0,0,1,3'd1,32'h0000_0206,32'hFFFF_1234,32'h0,        0, 2, 1, 32'h0000_0204,4'b1100,32'h1234_1234,1, 0, 32'h0,        0};
    vecs[11] = '{0,0,1,3'd0,32'h0000_0208,32'hDEAD_BEEF,32'h0,        0, 2, 1, 32'h0000_0208,4'b1111,32'hDEAD_BEEF,1, 0, 32'h0,        0};
    vecs[12] = '{0,1,1,3'd3,32'h0000_0203,32'h0000_0055,32'h0,        0, 2, 1, 32'h0000_0200,4'b1000,32'h5555_5555,1, 0, 32'h0,        0};
    vecs[13] = '{0,0,1,3'd0,32'h0000_0202,32'h1111_2222,32'h0,        0, 1, 0, 32'h0,        4'b0000,32'h0,        0, 1, 32'h0,        1};
    vecs[14] = '{0,1,0,3'd1,32'h0000_0101,32'h0,        32'h0,        0, 1, 0, 32'h0,        4'b0000,32'h0,        0, 1, 32'h0,        1};
    vecs[15] = '{0,1,0,3'd0,32'h0000_0300,32'h0,        32'h7777_7777,1, 5, 4, 32'h0000_0300,4'b1111,32'h0,        0, 1, 32'h0,        1};

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_memread = 1'b0; d_memwrite = 1'b0; d_mode = '0; d_addr = '0; d_wdata = '0;
    #3;
    checkOutput("reset_mem_en", {31'h0, mem_en}, 32'h0);
    checkOutput("reset_mem_be", {28'h0, mem_be}, 32'h0);
    checkOutput("reset_ready", {30'h0, if_ready, d_ready}, 32'h0);
    checkOutput("reset_d_err", {31'h0, d_err}, 32'h0);
    checkOutput("reset_rdata", d_rdata | if_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);

    // Stray acks while idle must not produce any response or issue.
    @(posedge clk); #1 stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 stray_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("stray_no_ready", {30'h0, if_ready, d_ready}, 32'h0);
      checkOutput("stray_no_en", {31'h0, mem_en}, 32'h0);
    end

    // Contention: data wins, fetch follows after d_ready, neither repeats.
    mem_img[32'h100] = 32'h80FF_0000;
    mem_img[32'h40]  = 32'h1234_5678;
    mem_q.push_back('{32'h100, 4'b1111, 32'h0, 1'b0});
    mem_q.push_back('{32'h40, 4'b1111, 32'h0, 1'b0});
    d_q.push_back('{32'h80FF_0000, 1'b0, 1'b1});
    if_q.push_back(32'h1234_5678);
    d_done = 1'b0; f_done = 1'b0; d_n = -1; f_n = -1;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40;
    d_memread = 1'b1; d_mode = 3'd0; d_addr = 32'h100;
    for (int n = 0; n < 20 && !(d_done && f_done); n++) begin
      @(negedge clk);
      if (d_ready && !d_done) begin d_done = 1'b1; d_n = n; end
      if (if_ready && !f_done) begin f_done = 1'b1; f_n = n; end
      @(posedge clk); #1;
      if (d_done) d_memread = 1'b0;
      if (f_done) if_req = 1'b0;
    end
    checkOutput("contend_d_latency", d_n, 2);
    checkOutput("contend_if_latency", f_n, 4);
    repeat (3) @(negedge clk);
    checkOutput("contend_sb_empty", mem_q.size() + d_q.size() + if_q.size(), 0);

    // Reset during BUSY_D: mem_en drops without a clock edge, no d_ready.
    mem_q.push_back('{32'h100, 4'b1111, 32'h0, 1'b0});
    ack_enable = 1'b0;
    @(posedge clk); #1;
    d_memread = 1'b1; d_mode = 3'd0; d_addr = 32'h100;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy_en", {31'h0, mem_en}, 32'h1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_async_en", {31'h0, mem_en}, 32'h0);
    checkOutput("rst_async_be", {28'h0, mem_be}, 32'h0);
    checkOutput("rst_async_we", {31'h0, mem_we}, 32'h0);
    d_memread = 1'b0;
    @(posedge clk); #1 reset = 1'b0; ack_enable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_no_ready", {31'h0, d_ready}, 32'h0);
    end
    applyStimulus(vecs[5], 5);

    repeat (3) @(negedge clk);
    checkOutput("final_sb_empty", mem_q.size() + d_q.size() + if_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, maximum cycles waiting for mem_ack before abort (1..255).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port if_req, input, 1, instruction-fetch request, held until if_ready.
REQ-005 SHALL have port if_addr, input, 32, fetch byte address.
REQ-006 SHALL have port if_ready, output, 1, one-cycle fetch completion pulse.
REQ-007 SHALL have port if_rdata, output, 32, fetched word, valid while if_ready=1.
REQ-008 SHALL have ports d_memread and d_memwrite, input, 1 each, data-access request, held until d_ready.
REQ-009 SHALL have port d_mode, input, 3, access size: 0 word, 1 half, 2 half-unsigned, 3 byte, 4 byte-unsigned; 5-7 treated as word.
REQ-010 SHALL have ports d_addr and d_wdata, input, 32 each, data byte address and store data.
REQ-011 SHALL have ports d_ready, output, 1, one-cycle completion pulse; d_rdata, output, 32, extended load data, valid while d_ready=1.
REQ-012 SHALL have port d_err, output, 1, pulses with d_ready on a misaligned or timed-out data access.
REQ-013 SHALL have port stall, output, 1, pipeline hold: (if_req & ~if_ready) | ((d_memread|d_memwrite) & ~d_ready).
REQ-014 SHALL have memory-side ports mem_en, mem_we (output, 1), mem_be (output, 4), mem_addr and mem_wdata (output, 32), mem_rdata (input, 32), and mem_ack (input, 1).

Function
REQ-015 SHALL implement states IDLE, BUSY_D and BUSY_IF.
REQ-016 In IDLE, an aligned data request SHALL win over if_req; the winner is latched and the next state is BUSY_D or BUSY_IF.
REQ-017 A requester whose ready output is 1 in the current cycle SHALL be ignored in that cycle, so that a held request is not issued twice.
REQ-018 When both d_memread and d_memwrite are 1, the access SHALL be treated as a write.
REQ-019 In BUSY_* states:
- mem_en=1 and mem_addr={addr[31:2],2'b00}.
- mem_we, mem_be and mem_wdata are driven from latched values and held stable until the state exits.
REQ-020 mem_be SHALL be: word 1111; half 0011 when addr[1]=0 and 1100 when addr[1]=1; byte 0001 shifted left by addr[1:0]; fetch 1111.
REQ-021 Store data SHALL be replicated into every byte lane: the byte repeated 4 times, or the half repeated 2 times.
REQ-022 Load data SHALL be the lane selected by addr, sign-extended for modes 1 and 3, zero-extended for modes 2 and 4.
REQ-023 A clock edge in BUSY_* with mem_ack=1 SHALL:
- register the read data;
- pulse the matching ready output for exactly the next cycle;
- return the state to IDLE.
REQ-024 Minimum latency SHALL be 2 cycles: request sampled at edge 0, mem_en high during cycle 1, ack in cycle 1, ready high in cycle 2.
REQ-025 An 8-bit wait counter SHALL clear on entry to BUSY_* and increment each cycle without ack. On reaching TIMEOUT:
- abort to IDLE;
- pulse ready with rdata=0;
- assert d_err for data accesses; fetch timeout gives if_ready with 0.
REQ-026 A misaligned data request (word with addr[1:0]≠0, half with addr[0]≠0) SHALL NOT access memory; d_ready and d_err pulse on the cycle after sampling, with d_rdata=0.
REQ-027 mem_ack arriving in IDLE SHALL be ignored.
REQ-028 if_rdata and d_rdata SHALL be 0 whenever their ready output is 0.

Reset
REQ-029 reset=1 SHALL immediately force: state IDLE, mem_en=0, mem_we=0, mem_be=0, all ready/err pulses 0, counter 0, rdata registers 0.
REQ-030 Reset mid-transaction SHALL abandon the access with no ready pulse; the requester re-issues after reset.

Structure
REQ-031 A shared package SHALL hold: the d_mode encodings, the state enumeration, and the width of the TIMEOUT counter.
REQ-032 Byte-enable generation, store replication and load extension SHALL live in one combinational sub-module, mem_lane_align.

Verification
REQ-033 Bench SHALL cover the following directed scenarios:
- Fetch only: if_req, addr 0x40, ack 1 cycle after mem_en, rdata 0x12345678 → if_ready in cycle 2 with 0x12345678; stall high in cycles 0-1.
- Contention: if_req and lw to 0x100 in the same cycle → data access served first; fetch issued after d_ready; neither issued twice.
- Loads: lb at 0x103 with memory word 0x80FF0000 → 0xFFFFFF80; lbu → 0x00000080; lh at 0x102 → 0xFFFF80FF; lhu → 0x000080FF.
- Store: sb 0xAB at 0x201 → mem_be=0010, mem_wdata=0xABABABAB, mem_addr=0x200. Misaligned sw at 0x202 → no mem_en, d_ready and d_err pulse.
- Timeout: ack never arrives, TIMEOUT=4 → abort after 4 waiting cycles with d_err=1 and d_rdata=0; a later stray mem_ack is ignored.
- Reset: reset asserted during BUSY_D → mem_en drops with no clock edge; no d_ready pulse; next request completes normally.
